dff_checker: RTL

DFF_CHECKER -- requirements
Module: dff_checker

---
 rtl/dff_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/dff_checker.sv
// Online checker for a single D flip-flop: compares observed Q against an ideal one-cycle-delayed copy of D.
// Optional macro DFF_CHECKER_QB_CHECK_EN also flags compares where QB is not the complement of Q.
module dff_checker #(
  parameter int N_CHECKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       d_obs,
  input  logic       q_obs,
  input  logic       qb_obs,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] err_cnt,
  output logic       err_flag,
  output logic [7:0] first_err_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(N_CHECKS - 1);

  logic [1:0] state_r;
  logic [1:0] state_s;
  logic       exp_q_r;
  logic [7:0] idx_r;
  logic       mismatch_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

`ifdef DFF_CHECKER_QB_CHECK_EN
  assign mismatch_s = (q_obs != exp_q_r) || (qb_obs == q_obs);
`else
  logic unused_qb;
  assign unused_qb  = qb_obs;
  assign mismatch_s = (q_obs != exp_q_r);
`endif

  // Next-state decode; abort overrides everything, start is only honoured when not busy.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = start ? PRIME : IDLE;
        PRIME:   state_s = CHECK;
        CHECK:   state_s = (idx_r == LAST_IDX) ? DONE : CHECK;
        DONE:    state_s = start ? PRIME : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, registered status outputs, expected-Q tracking and result counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      exp_q_r       <= 1'b0;
      idx_r         <= 8'd0;
      pass_cnt      <= 8'd0;
      err_cnt       <= 8'd0;
      err_flag      <= 1'b0;
      first_err_idx <= 8'hFF;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == PRIME) || (state_s == CHECK);
      done    <= (state_s == DONE);
      if (!abort) begin
        case (state_r)
          IDLE, DONE: begin
            if (start) begin
              idx_r         <= 8'd0;
              pass_cnt      <= 8'd0;
              err_cnt       <= 8'd0;
              err_flag      <= 1'b0;
              first_err_idx <= 8'hFF;
            end
          end
          PRIME: begin
            exp_q_r <= d_obs;
          end
          CHECK: begin
            exp_q_r <= d_obs;
            idx_r   <= idx_r + 8'd1;
            if (mismatch_s) begin
              err_cnt  <= sat_inc(err_cnt);
              err_flag <= 1'b1;
              if (!err_flag) begin
                first_err_idx <= idx_r;
              end
            end else begin
              pass_cnt <= sat_inc(pass_cnt);
            end
          end
          default: begin
            idx_r <= idx_r;
          end
        endcase
      end
    end
  end

endmodule
